band_gain_ramp: RTL and testbench

//  Parametrised N-band gain stage for the equalizer, placed after the FIR bank and before the band summer.
//  - One shared squarer/multiplier, time-multiplexed across NUM_BANDS bands.
//  - Each band gain = square of its slide-pot reading, slewed per frame by RAMP_STEP (anti zipper noise).
//  - Output is saturated to AUDIO_W; a sticky clip flag is kept per band.

---
 rtl/band_gain_ramp.sv | 192 +++++++++++++++++++
 tb/tb_band_gain_ramp.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/band_gain_ramp.sv
// N-band gain stage: per-band gain is the square of the pot reading, slewed per frame,
// applied to each band's sample through one time-shared pipeline with saturation.
//
// state | meaning
// IDLE  | waiting for a frame strobe
// ISSUE | one band per cycle enters the pipeline, idx = band number
// DRAIN | two cycles while the last band leaves the pipeline
module band_gain_ramp #(
    parameter int NUM_BANDS = 5,
    parameter int AUDIO_W   = 16,
    parameter int POT_W     = 12,
    parameter int FRAC_BITS = 10,
    parameter int RAMP_STEP = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           vld_in,
    input  logic [NUM_BANDS*AUDIO_W-1:0]   audio_in,
    input  logic [NUM_BANDS*POT_W-1:0]     pot_in,
    input  logic                           clr_clip,
    output logic                           busy,
    output logic                           vld_out,
    output logic [NUM_BANDS*AUDIO_W-1:0]   scaled_out,
    output logic [NUM_BANDS-1:0]           clip
);

    localparam int IDX_W  = (NUM_BANDS > 2) ? $clog2(NUM_BANDS) : 1;
    localparam int SQ_W   = 2 * POT_W;
    localparam int PROD_W = POT_W + 1 + AUDIO_W;
    localparam int HI_LO  = FRAC_BITS + AUDIO_W - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);
    localparam logic [POT_W-1:0] STEP     = POT_W'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                         state;
    logic [IDX_W-1:0]               idx;
    logic                           drain_cnt;
    logic [NUM_BANDS*AUDIO_W-1:0]   audio_lat;
    logic [NUM_BANDS*POT_W-1:0]     pot_lat;
    logic [POT_W-1:0]               gain_cur [NUM_BANDS];

    logic                           s1_vld;
    logic [IDX_W-1:0]               s1_idx;
    logic [POT_W-1:0]               s1_gain;
    logic signed [AUDIO_W-1:0]      s1_audio;

    logic                           s2_vld;
    logic [IDX_W-1:0]               s2_idx;
    logic signed [PROD_W-1:0]       prod;

    logic [POT_W-1:0]               cur_pot;
    logic [POT_W-1:0]               cur_gain;
    logic [SQ_W-1:0]                sq;
    logic [POT_W-1:0]               tgt;
    logic [POT_W-1:0]               nxt_gain;
    logic [PROD_W-1-HI_LO:0]        hi_bits;
    logic                           ovf;
    logic [AUDIO_W-1:0]             sat_res;
    logic [NUM_BANDS-1:0]           set_mask;

    assign cur_pot  = pot_lat[idx*POT_W +: POT_W];
    assign cur_gain = gain_cur[idx];
    assign sq       = SQ_W'(cur_pot) * SQ_W'(cur_pot);
    assign tgt      = sq[SQ_W-1:POT_W];

    // Slew limiter: step toward the target, landing on it exactly when close enough.
    always_comb begin
        nxt_gain = tgt;
        if (RAMP_STEP != 0) begin
            if (tgt > cur_gain) begin
                if ((tgt - cur_gain) > STEP)
                    nxt_gain = cur_gain + STEP;
            end else if ((cur_gain - tgt) > STEP) begin
                nxt_gain = cur_gain - STEP;
            end
        end
    end

    assign hi_bits = prod[PROD_W-1:HI_LO];
    assign ovf     = !((&hi_bits) || (~|hi_bits));

    always_comb begin
        sat_res = prod[HI_LO:FRAC_BITS];
        if (ovf)
            sat_res = prod[PROD_W-1] ? {1'b1, {(AUDIO_W-1){1'b0}}}
                                     : {1'b0, {(AUDIO_W-1){1'b1}}};
    end

    always_comb begin
        set_mask = '0;
        if (s2_vld && ovf)
            set_mask[s2_idx] = 1'b1;
    end

    // A strobe seen on the last drain cycle starts the next frame back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            drain_cnt <= 1'b0;
            audio_lat <= '0;
            pot_lat   <= '0;
            busy      <= 1'b0;
            vld_out   <= 1'b0;
        end else begin
            vld_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (vld_in) begin
                        audio_lat <= audio_in;
                        pot_lat   <= pot_in;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (idx == LAST_IDX) begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        vld_out <= 1'b1;
                        if (vld_in) begin
                            audio_lat <= audio_in;
                            pot_lat   <= pot_in;
                            idx       <= '0;
                            state     <= ISSUE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_BANDS; k++)
                gain_cur[k] <= '0;
            s1_vld   <= 1'b0;
            s1_idx   <= '0;
            s1_gain  <= '0;
            s1_audio <= '0;
        end else begin
            s1_vld <= (state == ISSUE);
            if (state == ISSUE) begin
                gain_cur[idx] <= nxt_gain;
                s1_gain       <= nxt_gain;
                s1_audio      <= audio_lat[idx*AUDIO_W +: AUDIO_W];
                s1_idx        <= idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld <= 1'b0;
            s2_idx <= '0;
            prod   <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                prod   <= PROD_W'($signed({1'b0, s1_gain})) * PROD_W'(s1_audio);
                s2_idx <= s1_idx;
            end
        end
    end

    // Clear first, then OR in new saturation so a same-cycle set survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scaled_out <= '0;
            clip       <= '0;
        end else begin
            clip <= (clr_clip ? '0 : clip) | set_mask;
            if (s2_vld)
                scaled_out[s2_idx*AUDIO_W +: AUDIO_W] <= sat_res;
        end
    end

endmodule

// File: tb/tb_band_gain_ramp.sv
// Directed bench for band_gain_ramp: one instance without slew, one with RAMP_STEP=64.
module tb_band_gain_ramp;

    localparam int NB = 5;
    localparam int AW = 16;
    localparam int PW = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            vld_in;
    logic [NB*AW-1:0] audio_in;
    logic [NB*PW-1:0] pot_in;
    logic            clr_clip;

    logic            busy_a, vld_out_a, busy_b, vld_out_b;
    logic [NB*AW-1:0] scaled_a, scaled_b;
    logic [NB-1:0]   clip_a, clip_b;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    band_gain_ramp #(.NUM_BANDS(NB), .AUDIO_W(AW), .POT_W(PW), .FRAC_BITS(10), .RAMP_STEP(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .audio_in(audio_in), .pot_in(pot_in),
        .clr_clip(clr_clip), .busy(busy_a), .vld_out(vld_out_a), .scaled_out(scaled_a), .clip(clip_a));

    band_gain_ramp #(.NUM_BANDS(NB), .AUDIO_W(AW), .POT_W(PW), .FRAC_BITS(10), .RAMP_STEP(64)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .audio_in(audio_in), .pot_in(pot_in),
        .clr_clip(clr_clip), .busy(busy_b), .vld_out(vld_out_b), .scaled_out(scaled_b), .clip(clip_b));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_all(input logic [AW-1:0] a, input logic [PW-1:0] p);
        for (int k = 0; k < NB; k++) begin
            audio_in[k*AW +: AW] = a;
            pot_in[k*PW +: PW]   = p;
        end
    endtask

    function automatic logic [NB*AW-1:0] rep(input logic [AW-1:0] v);
        logic [NB*AW-1:0] r;
        for (int k = 0; k < NB; k++) r[k*AW +: AW] = v;
        return r;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_frame();
        int lat;
        @(negedge clk);
        vld_in = 1'b1;
        @(posedge clk);
        #1 vld_in = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(posedge clk);
            #1;
            if (vld_out_a) lat = n;
        end
        chk("frame_lat", lat, 7);
    endtask

    logic [NB*AW-1:0] exp_v;
    int pulses, first_t, second_t, lat6;

    initial begin
        rst_n = 1'b0; vld_in = 1'b0; clr_clip = 1'b0;
        audio_in = '0; pot_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        chk("rst_busy", busy_b, 1'b0);
        chk("rst_vld", vld_out_b, 1'b0);
        chk("rst_scaled", scaled_b, '0);
        chk("rst_clip", clip_a, '0);

        // unity gain, alternating sign
        for (int k = 0; k < NB; k++) begin
            audio_in[k*AW +: AW] = (k % 2 == 0) ? 16'h1234 : 16'hEDCC;
            pot_in[k*PW +: PW]   = 12'h800;
        end
        exp_v = {16'h1234, 16'hEDCC, 16'h1234, 16'hEDCC, 16'h1234};
        run_frame();
        chk("unity_out", scaled_a, exp_v);
        chk("unity_clip", clip_a, '0);
        @(posedge clk); #1;
        chk("vld_one_cycle", vld_out_a, 1'b0);

        // near-max gain with saturation on bands 1 and 2
        set_all(16'h1000, 12'hFFF);
        audio_in[1*AW +: AW] = 16'h7FFF;
        audio_in[2*AW +: AW] = 16'h8000;
        audio_in[4*AW +: AW] = 16'h0000;
        run_frame();
        chk("gain4094_out", scaled_a, {16'h0000, 16'h3FF8, 16'h8000, 16'h7FFF, 16'h3FF8});
        chk("gain4094_clip", clip_a, 5'b00110);

        // clr_clip coincides with band 2 saturating (band 2 written at E0+5)
        set_all(16'h0000, 12'hFFF);
        audio_in[2*AW +: AW] = 16'h7FFF;
        @(negedge clk) vld_in = 1'b1;
        @(posedge clk);
        #1 vld_in = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) clr_clip = 1'b1;
        @(posedge clk);
        #1 clr_clip = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (vld_out_a) break;
        end
        chk("clr_vs_set_clip", clip_a, 5'b00100);
        chk("clr_vs_set_out", scaled_a[2*AW +: AW], 16'h7FFF);
        @(negedge clk) clr_clip = 1'b1;
        @(negedge clk) clr_clip = 1'b0;
        chk("clr_only", clip_a, 5'b00000);

        // slew up then down
        do_reset();
        set_all(16'h0400, 12'h800);
        for (int f = 1; f <= 20; f++) begin
            run_frame();
            chk($sformatf("ramp_up_%0d", f), scaled_b, rep(16'((f * 64 > 1024) ? 1024 : f * 64)));
        end
        set_all(16'h0400, 12'h000);
        for (int f = 1; f <= 17; f++) begin
            run_frame();
            chk($sformatf("ramp_dn_%0d", f), scaled_b, rep(16'((1024 - f * 64 < 0) ? 0 : 1024 - f * 64)));
        end

        // held strobe: back-to-back frames every 7 cycles
        set_all(16'h1234, 12'h000);
        pulses = 0; first_t = -1; second_t = -1;
        @(negedge clk) vld_in = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            @(posedge clk); #1;
            if (vld_out_a) begin
                pulses++;
                if (first_t < 0) first_t = t;
                else if (second_t < 0) second_t = t;
            end
        end
        @(negedge clk) vld_in = 1'b0;
        chk("held_pulses", pulses, 5);
        chk("held_first", first_t, 8);
        chk("held_period", second_t - first_t, 7);
        for (int n = 0; n < 20 && busy_a; n++) @(negedge clk);
        chk("held_idle", busy_a, 1'b0);

        // reset in the middle of a frame
        set_all(16'h0400, 12'h800);
        run_frame();
        chk("pre_rst_out", scaled_b, rep(16'd64));
        @(negedge clk) vld_in = 1'b1;
        @(posedge clk);
        #1 vld_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("mid_rst_scaled", scaled_b, '0);
        chk("mid_rst_busy", busy_b, 1'b0);
        chk("mid_rst_clip", clip_a, '0);
        @(negedge clk) rst_n = 1'b1;
        lat6 = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (vld_out_b || busy_b) lat6++;
        end
        chk("no_vld_after_rst", lat6, 0);
        run_frame();
        chk("post_rst_out", scaled_b, rep(16'd64));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
